// File: rtl/alu_b_operand_stage.sv
// Purpose: ALU operand-B select with rt forwarding (EX/MEM, MEM/WB) between ID and EX; forwarding only when ALU_B_FWD_EN is defined.
// Latency: 1 cycle from accept (in_valid && in_ready) to out_valid; 1 operand/cycle when out_ready stays high.
// Backpressure: in_ready = !out_valid || out_ready; held operand stays stable while out_valid && !out_ready.
module alu_b_operand_stage #(
    parameter int DATA_W  = 32,
    parameter int IMM_W   = 16,
    parameter int SHAMT_W = 5,
    parameter int REG_AW  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_src,
    input  logic [REG_AW-1:0] rt_idx,
    input  logic [DATA_W-1:0] read_data2,
    input  logic [IMM_W-1:0]  imm,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic              ex_mem_wr_en,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic [DATA_W-1:0] ex_mem_result,
    input  logic              mem_wb_wr_en,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic [DATA_W-1:0] mem_wb_result,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_b,
    output logic [DATA_W-1:0] store_data,
    output logic [1:0]        fwd_sel
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] rt_val;
    logic [1:0]        rt_sel;
    logic [DATA_W-1:0] alu_b_nxt;
    logic              accept;

`ifdef ALU_B_FWD_EN
    // Resolve rt: EX/MEM wins over MEM/WB, register 0 is never forwarded
    always_comb begin
        rt_val = read_data2;
        rt_sel = 2'b00;
        if (ex_mem_wr_en && (ex_mem_rd != '0) && (ex_mem_rd == rt_idx)) begin
            rt_val = ex_mem_result;
            rt_sel = 2'b01;
        end else if (mem_wb_wr_en && (mem_wb_rd != '0) && (mem_wb_rd == rt_idx)) begin
            rt_val = mem_wb_result;
            rt_sel = 2'b10;
        end
    end
`else
    // Without forwarding the hazard unit stalls, so rt always comes from the register file
    assign rt_val = read_data2;
    assign rt_sel = 2'b00;

    logic unused_fwd;
    assign unused_fwd = ^{ex_mem_wr_en, ex_mem_rd, ex_mem_result,
                          mem_wb_wr_en, mem_wb_rd, mem_wb_result, rt_idx};
`endif

    // Operand-B source select; immediates and shamt are widened to the datapath
    always_comb begin
        alu_b_nxt = rt_val;
        case (alu_src)
            2'b00:   alu_b_nxt = rt_val;
            2'b01:   alu_b_nxt = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
            2'b10:   alu_b_nxt = {{(DATA_W-IMM_W){1'b0}}, imm};
            default: alu_b_nxt = {{(DATA_W-SHAMT_W){1'b0}}, shamt};
        endcase
    end

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Output register FSM; flush empties the stage and drops any same-cycle accept without touching data
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            out_valid  <= 1'b0;
            alu_b      <= '0;
            store_data <= '0;
            fwd_sel    <= 2'b00;
        end else begin
            if (accept && !flush) begin
                alu_b      <= alu_b_nxt;
                store_data <= rt_val;
                fwd_sel    <= rt_sel;
            end
            if (flush) begin
                state     <= EMPTY;
                out_valid <= 1'b0;
            end else begin
                case (state)
                    EMPTY: begin
                        if (accept) begin
                            state     <= FULL;
                            out_valid <= 1'b1;
                        end
                    end
                    FULL: begin
                        if (out_ready && !accept) begin
                            state     <= EMPTY;
                            out_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_b_operand_stage.sv
// Directed bench for alu_b_operand_stage: operand select, forwarding, stall, flush, async reset.
// Expected values adapt to whether ALU_B_FWD_EN is defined for the build.
module tb_alu_b_operand_stage;

`ifdef ALU_B_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  alu_src;
    logic [4:0]  rt_idx;
    logic [31:0] read_data2;
    logic [15:0] imm;
    logic [4:0]  shamt;
    logic        ex_mem_wr_en;
    logic [4:0]  ex_mem_rd;
    logic [31:0] ex_mem_result;
    logic        mem_wb_wr_en;
    logic [4:0]  mem_wb_rd;
    logic [31:0] mem_wb_result;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_b;
    logic [31:0] store_data;
    logic [1:0]  fwd_sel;

    int n_checks;
    int n_fail;

    alu_b_operand_stage #(
        .DATA_W(32), .IMM_W(16), .SHAMT_W(5), .REG_AW(5)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_src(alu_src), .rt_idx(rt_idx), .read_data2(read_data2),
        .imm(imm), .shamt(shamt),
        .ex_mem_wr_en(ex_mem_wr_en), .ex_mem_rd(ex_mem_rd), .ex_mem_result(ex_mem_result),
        .mem_wb_wr_en(mem_wb_wr_en), .mem_wb_rd(mem_wb_rd), .mem_wb_result(mem_wb_result),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_b(alu_b), .store_data(store_data), .fwd_sel(fwd_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [1:0] src, input logic [4:0] rt, input logic [31:0] rd2,
                       input logic [15:0] im, input logic [4:0] sh);
        in_valid   = 1'b1;
        alu_src    = src;
        rt_idx     = rt;
        read_data2 = rd2;
        imm        = im;
        shamt      = sh;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1; in_valid = 1'b0; alu_src = 2'b00; rt_idx = '0; read_data2 = '0;
        imm = '0; shamt = '0; ex_mem_wr_en = 1'b0; ex_mem_rd = '0; ex_mem_result = '0;
        mem_wb_wr_en = 1'b0; mem_wb_rd = '0; mem_wb_result = '0; flush = 1'b0; out_ready = 1'b1;

        // Reset state
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_store_data", store_data, 32'd0);
        chk("rst_fwd_sel", {30'b0, fwd_sel}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        tick();
        reset = 1'b0;

        // Sign-extended immediate
        req(2'b01, 5'd3, 32'h0000_1234, 16'hFFFE, 5'd0);
        tick();
        chk("sext_valid", {31'b0, out_valid}, 32'd1);
        chk("sext_alu_b", alu_b, 32'hFFFF_FFFE);
        chk("sext_store", store_data, 32'h0000_1234);

        // Zero-extended immediate, back-to-back
        req(2'b10, 5'd3, 32'h0000_1234, 16'hFFFE, 5'd0);
        tick();
        chk("zext_valid", {31'b0, out_valid}, 32'd1);
        chk("zext_alu_b", alu_b, 32'h0000_FFFE);

        // Positive sign extension
        req(2'b01, 5'd3, 32'h0000_1234, 16'h7FFF, 5'd0);
        tick();
        chk("sext_pos_alu_b", alu_b, 32'h0000_7FFF);

        // Shift amount
        req(2'b11, 5'd3, 32'h0000_1234, 16'hFFFF, 5'h1F);
        tick();
        chk("shamt_alu_b", alu_b, 32'h0000_001F);

        // Both stages match rt=8: EX/MEM has priority
        ex_mem_wr_en = 1'b1; ex_mem_rd = 5'd8; ex_mem_result = 32'h11;
        mem_wb_wr_en = 1'b1; mem_wb_rd = 5'd8; mem_wb_result = 32'h22;
        req(2'b00, 5'd8, 32'd5, 16'h0, 5'd0);
        tick();
        chk("fwd_exmem_alu_b", alu_b, FWD ? 32'h11 : 32'h5);
        chk("fwd_exmem_sel", {30'b0, fwd_sel}, FWD ? 32'd1 : 32'd0);
        chk("fwd_exmem_store", store_data, FWD ? 32'h11 : 32'h5);

        // Only MEM/WB matches
        ex_mem_wr_en = 1'b0;
        tick();
        chk("fwd_memwb_alu_b", alu_b, FWD ? 32'h22 : 32'h5);
        chk("fwd_memwb_sel", {30'b0, fwd_sel}, FWD ? 32'd2 : 32'd0);

        // store_data forwards even when alu_b takes the immediate
        ex_mem_wr_en = 1'b1; ex_mem_result = 32'h33;
        req(2'b01, 5'd8, 32'd5, 16'h8000, 5'd0);
        tick();
        chk("store_indep_alu_b", alu_b, 32'hFFFF_8000);
        chk("store_indep_data", store_data, FWD ? 32'h33 : 32'h5);

        // Register 0 is never forwarded
        ex_mem_rd = 5'd0; ex_mem_result = 32'd7;
        mem_wb_rd = 5'd0; mem_wb_result = 32'd9;
        req(2'b00, 5'd0, 32'd0, 16'h0, 5'd0);
        tick();
        chk("r0_alu_b", alu_b, 32'd0);
        chk("r0_fwd_sel", {30'b0, fwd_sel}, 32'd0);
        ex_mem_wr_en = 1'b0; mem_wb_wr_en = 1'b0;

        // Known held value before stall
        req(2'b10, 5'd1, 32'd0, 16'h5555, 5'd0);
        tick();
        chk("pre_stall_alu_b", alu_b, 32'h0000_5555);

        // Stall for 3 cycles with a new request pending
        out_ready = 1'b0;
        req(2'b10, 5'd1, 32'd0, 16'hAAAA, 5'd0);
        #1;
        chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_valid", {31'b0, out_valid}, 32'd1);
            chk("stall_alu_b", alu_b, 32'h0000_5555);
            chk("stall_in_ready_hold", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        chk("release_alu_b", alu_b, 32'h0000_AAAA);
        chk("release_valid", {31'b0, out_valid}, 32'd1);
        req(2'b10, 5'd1, 32'd0, 16'hBBBB, 5'd0);
        tick();
        chk("next_alu_b", alu_b, 32'h0000_BBBB);
        in_valid = 1'b0;
        tick();
        chk("drain_valid", {31'b0, out_valid}, 32'd0);
        chk("drain_alu_b_kept", alu_b, 32'h0000_BBBB);
        tick();
        chk("no_dup_valid", {31'b0, out_valid}, 32'd0);

        // Flush concurrent with accept while FULL
        req(2'b10, 5'd1, 32'd0, 16'h0C0C, 5'd0);
        tick();
        chk("preflush_alu_b", alu_b, 32'h0000_0C0C);
        req(2'b10, 5'd1, 32'd0, 16'h0D0D, 5'd0);
        flush = 1'b1;
        tick();
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_alu_b_kept", alu_b, 32'h0000_0C0C);
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("post_flush_valid", {31'b0, out_valid}, 32'd0);

        // Asynchronous reset while FULL
        req(2'b10, 5'd1, 32'h99, 16'h0E0E, 5'd0);
        tick();
        chk("prereset_valid", {31'b0, out_valid}, 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_alu_b", alu_b, 32'd0);
        chk("arst_store", store_data, 32'd0);
        chk("arst_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
